// File: rtl/booth_mul_unit.sv
// Multi-cycle radix-2 Booth multiplier for RISC-V MUL/MULH/MULHSU/MULHU with tag and valid/yumi retire.
// Optional MUL_EARLY_OUT_EN: finish with one barrel shift once the remaining multiplier bits are uniform.
module booth_mul_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             valid_out,
  input  logic             yumi_in,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int unsigned XW = WIDTH + 1;
  localparam int unsigned AW = WIDTH + 2;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 2);

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b11;

`ifdef MUL_EARLY_OUT_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2, S_FINISH = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t           r_state;
  logic [AW-1:0]    r_a;
  logic [XW-1:0]    r_q;
  logic             r_qm1;
  logic [XW-1:0]    r_b;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_tag_out;

  logic [XW-1:0]    w_a_ext;
  logic [XW-1:0]    w_b_ext;
  logic [AW-1:0]    w_mcand;
  logic [AW-1:0]    w_sum;
  logic [AW-1:0]    w_a_nx;
  logic [XW-1:0]    w_q_nx;
  logic [PW-1:0]    w_step_prod;

  function automatic logic [WIDTH-1:0] f_sel(input logic [1:0] sel_op, input logic [PW-1:0] prod);
    return (sel_op == OP_MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
  endfunction

  // Operand extension: op_a signed unless MULHU, op_b signed only for MUL/MULH.
  assign w_a_ext = {(op != OP_MULHU) & op_a[WIDTH-1], op_a};
  assign w_b_ext = {~op[1] & op_b[WIDTH-1], op_b};
  assign w_mcand = {r_b[XW-1], r_b};

  // One Booth iteration: conditional add/subtract followed by arithmetic shift of {A,Q,Q-1}.
  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_a + w_mcand;
      2'b10:   w_sum = r_a - w_mcand;
      default: w_sum = r_a;
    endcase
  end

  assign w_a_nx      = {w_sum[AW-1], w_sum[AW-1:1]};
  assign w_q_nx      = {w_sum[0], r_q[XW-1:1]};
  assign w_step_prod = PW'({w_a_nx, w_q_nx});

`ifdef MUL_EARLY_OUT_EN
  logic [XW:0]   w_pow;
  logic [XW-1:0] w_mask;
  logic [XW-1:0] w_rem;
  logic          w_early;
  logic [PW-1:0] w_fin_prod;

  // Remaining Booth pairs are all no-ops when the unconsumed Q bits and Q-1 agree.
  assign w_pow      = (XW + 1)'(1) << r_cnt;
  assign w_mask     = XW'(w_pow - (XW + 1)'(1));
  assign w_rem      = r_q & w_mask;
  assign w_early    = (r_cnt > CW'(1)) && (r_qm1 ? (w_rem == w_mask) : (w_rem == '0));
  assign w_fin_prod = PW'($signed({r_a, r_q}) >>> r_cnt);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_result  <= '0;
      r_tag_out <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_b     <= w_a_ext;
            r_q     <= w_b_ext;
            r_qm1   <= 1'b0;
            r_a     <= '0;
            r_cnt   <= CW'(WIDTH + 1);
            r_op    <= op;
            r_tag   <= tag_in;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
`ifdef MUL_EARLY_OUT_EN
          if (w_early) begin
            r_state <= S_FINISH;
          end else
`endif
          begin
            r_a   <= w_a_nx;
            r_q   <= w_q_nx;
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_result  <= f_sel(r_op, w_step_prod);
              r_tag_out <= r_tag;
              r_state   <= S_DONE;
            end
          end
        end
`ifdef MUL_EARLY_OUT_EN
        S_FINISH: begin
          r_result  <= f_sel(r_op, w_fin_prod);
          r_tag_out <= r_tag;
          r_state   <= S_DONE;
        end
`endif
        S_DONE: begin
          if (yumi_in) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready     = (r_state == S_IDLE);
  assign valid_out = (r_state == S_DONE);
  assign result    = r_result;
  assign tag_out   = r_tag_out;

endmodule

// File: tb/tb_booth_mul_unit.sv
// Directed self-checking bench for booth_mul_unit (WIDTH=32, TAG_W=6); extra checks when MUL_EARLY_OUT_EN is defined.
module tb_booth_mul_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic          ready;
  logic [1:0]    op;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic [TW-1:0] tag_in;
  logic          flush;
  logic          valid_out;
  logic          yumi_in;
  logic [W-1:0]  result;
  logic [TW-1:0] tag_out;

  int errs   = 0;
  int checks = 0;

  booth_mul_unit #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready(ready), .op(op),
    .op_a(op_a), .op_b(op_b), .tag_in(tag_in), .flush(flush),
    .valid_out(valid_out), .yumi_in(yumi_in), .result(result), .tag_out(tag_out)
  );

  always #5 clk = ~clk;

  // Reference product built from plain wide signed multiplication.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [65:0]  ea;
    logic signed [65:0]  eb;
    logic signed [131:0] p;
    ea = (o == 2'b11) ? $signed({34'd0, a}) : $signed({{34{a[W-1]}}, a});
    eb = o[1] ? $signed({34'd0, b}) : $signed({{34{b[W-1]}}, b});
    p  = 132'(ea) * 132'(eb);
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic accept(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
    op = o; op_a = a; op_b = b; tag_in = t; valid_in = 1'b1;
    tick();
    valid_in = 1'b0; op_a = $urandom; op_b = $urandom; tag_in = TW'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!valid_out && lat < 200) begin
      tick();
      lat++;
    end
    if (!valid_out) begin
      checks++; errs++;
      $display("FAIL wait_done: valid_out never rose within %0d cycles", lat);
    end
  endtask

  task automatic consume();
    yumi_in = 1'b1;
    tick();
    yumi_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; yumi_in = 1'b0;
    op = 2'b00; op_a = '0; op_b = '0; tag_in = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (ready !== 1'b1)     begin errs++; $display("FAIL reset_ready: got %b want 1", ready); end
    checks++; if (valid_out !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    checks++; if (result !== '0)      begin errs++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (tag_out !== '0)     begin errs++; $display("FAIL reset_tag: got %h want 0", tag_out); end
  endtask

  task automatic test_mul_basic();
    int lat;
    accept(2'b00, 32'd7, 32'd6, 6'h15);
    wait_done(lat);
`ifndef MUL_EARLY_OUT_EN
    checks++; if (lat != 33) begin errs++; $display("FAIL basic_latency: got %0d want 33", lat); end
`else
    checks++; if (lat > 33 || lat < 2) begin errs++; $display("FAIL basic_latency: got %0d want 2..33", lat); end
`endif
    checks++; if (result !== 32'd42)  begin errs++; $display("FAIL basic_result: got %h want 2a", result); end
    checks++; if (tag_out !== 6'h15)  begin errs++; $display("FAIL basic_tag: got %h want 15", tag_out); end
    consume();
    checks++; if (valid_out !== 1'b0 || ready !== 1'b1)
      begin errs++; $display("FAIL basic_retire: valid_out=%b ready=%b want 0/1", valid_out, ready); end
  endtask

  task automatic test_signed();
    logic [1:0]   ops [4] = '{2'b00, 2'b01, 2'b01, 2'b00};
    logic [W-1:0] as  [4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
    logic [W-1:0] bs  [4] = '{32'd6, 32'd6, 32'h80000000, 32'h80000000};
    logic [W-1:0] exp [4] = '{32'hFFFFFFD6, 32'hFFFFFFFF, 32'h40000000, 32'h00000000};
    int lat;
    for (int i = 0; i < 4; i++) begin
      accept(ops[i], as[i], bs[i], TW'(i + 1));
      wait_done(lat);
      checks++; if (result !== exp[i])
        begin errs++; $display("FAIL signed_%0d: got %h want %h", i, result, exp[i]); end
      consume();
    end
  endtask

  task automatic test_unsigned();
    logic [1:0]   ops [6] = '{2'b11, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
    logic [W-1:0] as  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678, 32'hFFFFFFFE};
    logic [W-1:0] bs  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'h10, 32'd3};
    logic [W-1:0] exp [6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h23456780, 32'hFFFFFFFF};
    int lat;
    for (int i = 0; i < 6; i++) begin
      accept(ops[i], as[i], bs[i], TW'(i + 8));
      wait_done(lat);
      checks++; if (result !== exp[i] || tag_out !== TW'(i + 8))
        begin errs++; $display("FAIL unsigned_%0d: got %h tag %h want %h tag %h", i, result, tag_out, exp[i], TW'(i + 8)); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    accept(2'b00, 32'd100, 32'd3, 6'h2A);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      checks++; if (valid_out !== 1'b1 || result !== 32'd300 || tag_out !== 6'h2A)
        begin errs++; $display("FAIL hold_%0d: valid=%b result=%h tag=%h want 1/12c/2a", i, valid_out, result, tag_out); end
      tick();
    end
    consume();
    checks++; if (valid_out !== 1'b0 || ready !== 1'b1)
      begin errs++; $display("FAIL hold_release: valid_out=%b ready=%b want 0/1", valid_out, ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    accept(2'b11, 32'hDEADBEEF, 32'h10, 6'h33);
    tick(); tick();
    op = 2'b00; op_a = 32'd9; op_b = 32'd9; tag_in = 6'h01; valid_in = 1'b1;
    checks++; if (ready !== 1'b0) begin errs++; $display("FAIL busy_ready: got %b want 0", ready); end
    tick();
    valid_in = 1'b0;
    wait_done(lat);
    checks++; if (result !== 32'h0000000D || tag_out !== 6'h33)
      begin errs++; $display("FAIL b2b_first: got %h tag %h want d tag 33", result, tag_out); end
    consume();
    accept(2'b00, 32'h0000FFFF, 32'h0000FFFF, 6'h3C);
    wait_done(lat);
`ifndef MUL_EARLY_OUT_EN
    checks++; if (lat != 33) begin errs++; $display("FAIL b2b_latency: got %0d want 33", lat); end
`endif
    checks++; if (result !== 32'hFFFE0001 || tag_out !== 6'h3C)
      begin errs++; $display("FAIL b2b_second: got %h tag %h want fffe0001 tag 3c", result, tag_out); end
    consume();
  endtask

  task automatic test_flush_busy();
    bit seen = 1'b0;
    accept(2'b01, 32'h12345678, 32'h9ABCDEF0, 6'h11);
    repeat (9) tick();
    checks++; if (ready !== 1'b0 || valid_out !== 1'b0)
      begin errs++; $display("FAIL flush_pre: ready=%b valid=%b want 0/0", ready, valid_out); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if (ready !== 1'b1 || valid_out !== 1'b0)
      begin errs++; $display("FAIL flush_busy: ready=%b valid=%b want 1/0", ready, valid_out); end
    for (int i = 0; i < 40; i++) begin
      if (valid_out) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errs++; $display("FAIL flush_no_result: valid_out=1 want 0"); end
  endtask

  task automatic test_flush_done();
    int lat;
    bit seen = 1'b0;
    accept(2'b00, 32'd1234, 32'd5678, 6'h07);
    wait_done(lat);
    flush = 1'b1; yumi_in = 1'b1;
    tick();
    flush = 1'b0; yumi_in = 1'b0;
    checks++; if (valid_out !== 1'b0 || ready !== 1'b1)
      begin errs++; $display("FAIL flush_done: valid=%b ready=%b want 0/1", valid_out, ready); end
    op = 2'b00; op_a = 32'd3; op_b = 32'd3; tag_in = 6'h02; valid_in = 1'b1; flush = 1'b1;
    tick();
    valid_in = 1'b0; flush = 1'b0;
    checks++; if (ready !== 1'b1) begin errs++; $display("FAIL flush_drop: ready=%b want 1", ready); end
    for (int i = 0; i < 40; i++) begin
      if (valid_out) seen = 1'b1;
      tick();
    end
    checks++; if (seen) begin errs++; $display("FAIL flush_drop_result: valid_out=1 want 0"); end
  endtask

  task automatic test_reset_mid();
    accept(2'b00, 32'd3, 32'd5, 6'h09);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (ready !== 1'b1 || valid_out !== 1'b0 || result !== '0 || tag_out !== '0)
      begin errs++; $display("FAIL reset_mid: ready=%b valid=%b result=%h tag=%h want 1/0/0/0", ready, valid_out, result, tag_out); end
  endtask

  task automatic test_random();
    int lat;
    logic [1:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
`ifdef MUL_EARLY_OUT_EN
    int n = 1000;
`else
    int n = 200;
`endif
    for (int i = 0; i < n; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 8 == 1) b = W'($urandom_range(0, 7));
      if (i % 8 == 2) b = ~W'($urandom_range(0, 7));
      e = model(o, a, b);
      accept(o, a, b, TW'(i));
      wait_done(lat);
      checks++; if (result !== e)
        begin errs++; $display("FAIL random_%0d: op=%0d a=%h b=%h got %h want %h", i, o, a, b, result, e); end
      consume();
    end
  endtask

`ifdef MUL_EARLY_OUT_EN
  task automatic test_early_out();
    int lat;
    accept(2'b00, 32'd12345, 32'd0, 6'h05);
    wait_done(lat);
    checks++; if (lat > 3 || result !== 32'd0)
      begin errs++; $display("FAIL early_zero: lat=%0d result=%h want <=3/0", lat, result); end
    consume();
    accept(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'h06);
    wait_done(lat);
    checks++; if (result !== 32'd1)
      begin errs++; $display("FAIL early_neg: got %h want 1", result); end
    consume();
  endtask
`endif

  initial begin
    test_reset();
    test_mul_basic();
    test_signed();
    test_unsigned();
    test_backpressure();
    test_back_to_back();
    test_flush_busy();
    test_flush_done();
    test_reset_mid();
    test_random();
`ifdef MUL_EARLY_OUT_EN
    test_early_out();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/booth_mul_unit.md
# booth_mul_unit

Parametrised, signed/unsigned, multi-cycle radix-2 Booth multiplier for the integer-multiply execution lane. It accepts one RISC-V M-extension multiply (MUL/MULH/MULHSU/MULHU) per transaction, tagged with its ROB/reservation-station tag. It retires the selected WIDTH-bit half of the product through a valid/yumi handshake and supports pipeline flush.

## Interface
Parameters:
- WIDTH, 32: operand and result width; legal values are 8..64.
- TAG_W, 6: width of the opaque tag carried from issue to writeback.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- reset  in  1: reset, synchronous, active-high.
- valid_in  in  1: the issue stage presents an operation.
- ready  out  1: the unit is idle and can accept; transfer occurs when valid_in & ready.
- op  in  2: 00 MUL (low half), 01 MULH (s×s high), 10 MULHSU (op_a signed × op_b unsigned, high), 11 MULHU (u×u high).
- op_a  in  WIDTH: rs1 operand.
- op_b  in  WIDTH: rs2 operand.
- tag_in  in  TAG_W: tag captured at acceptance.
- flush  in  1: kill any in-flight or completed-but-unconsumed operation.
- valid_out  out  1: result and tag_out are valid.
- yumi_in  in  1: the consumer takes the result; only meaningful while valid_out=1.
- result  out  WIDTH: selected product half.
- tag_out  out  TAG_W: tag of the operation in result.

## Operation
- States: IDLE, BUSY, DONE (plus FINISH when MUL_EARLY_OUT_EN is set).
- Signedness per op:
  - op_a is signed for MUL, MULH and MULHSU; unsigned for MULHU.
  - op_b is signed for MUL and MULH; unsigned for MULHSU and MULHU.
- Accept (IDLE with valid_in):
  - Each operand is extended by one bit to WIDTH+1 (sign- or zero-extended per op).
  - Load: multiplicand B ← ext(op_a); Q ← ext(op_b); Q₋₁ ← 0; accumulator A (WIDTH+2 bits) ← 0.
  - Iteration counter ← WIDTH+1. Latch op and tag_in. Go to BUSY.
- BUSY (one iteration per cycle; add and shift happen in the same cycle):
  - Booth pair {Q[0],Q₋₁}: 01 adds B; 10 subtracts B; 00 and 11 leave A unchanged.
  - B is sign-extended to WIDTH+2 for the add or subtract.
  - Then {A,Q,Q₋₁} shifts right arithmetically by 1 and the counter decrements.
  - When the counter reaches 0, go to DONE.
- Entry to DONE:
  - The product is the low 2·WIDTH bits of {A,Q}.
  - result is registered: low WIDTH bits for MUL, bits [2·WIDTH-1:WIDTH] otherwise.
  - tag_out ← latched tag.
- DONE: valid_out=1. result and tag_out are held stable until yumi_in=1, then go to IDLE.
- Flush:
  - flush=1 in any state forces IDLE at the next edge and clears valid_out.
  - flush has priority over valid_in and yumi_in in the same cycle; the input is dropped.
- Reset:
  - Identical effect to flush; it also clears result and tag_out to 0.
  - Reset mid-operation abandons the operation without any output.

## Timing
- Values after the reset edge: ready=1, valid_out=0, result=0, tag_out=0; state IDLE.
- ready is 1 only in IDLE. ready and valid_out are decoded from registered state, with no combinational path from any input.
- Acceptance at edge k gives valid_out=1 in the cycle after edge k+WIDTH+1. Fixed latency is WIDTH+1 cycles (33 for WIDTH=32).
- yumi_in at edge m gives ready=1 after edge m. Minimum issue interval is WIDTH+3 cycles.
- yumi_in while valid_out=0 is ignored. valid_in outside IDLE is ignored and does not need to be held.

## Configuration
- MUL_EARLY_OUT_EN defined:
  - At every BUSY cycle, check whether all not-yet-consumed bits of Q, together with Q₋₁, are identical (all 0 or all 1).
  - If so, go to FINISH. FINISH performs a single arithmetic right shift of {A,Q} by the remaining count, then goes to DONE.
  - Latency becomes variable, between 2 and WIDTH+1 cycles. Results are bit-identical to the fixed-latency case.
- MUL_EARLY_OUT_EN undefined: the FINISH state and the shifter are absent, and latency is always exactly WIDTH+1 cycles.

## Test plan
- MUL 7 × 6, tag 0x15, yumi immediately -> result 42, tag_out 0x15. valid_out exactly 33 cycles after acceptance (macro off).
- -7 × 6:
  - MUL -> 0xFFFFFFD6.
  - MULH -> 0xFFFFFFFF.
  - 0x80000000 × 0x80000000 MULH -> 0x40000000; MUL -> 0x00000000.
- Unsigned and mixed signedness, 0xFFFFFFFF × 0xFFFFFFFF:
  - MULHU -> 0xFFFFFFFE.
  - MULHSU -> 0xFFFFFFFF.
  - MULH -> 0x00000000.
- Backpressure: hold yumi_in=0 for 10 cycles after valid_out rises -> result and tag_out stay stable. One yumi pulse -> valid_out drops and ready=1 the next cycle.
- Abort:
  - flush at iteration 10 -> IDLE next edge, no valid_out.
  - flush coincident with yumi_in in DONE -> valid_out drops.
  - reset mid-operation -> all outputs at reset values.
- MUL_EARLY_OUT_EN defined:
  - 12345 × 0 -> result 0 with latency ≤ 3.
  - -1 × -1 MUL -> 1.
  - Random 1000-vector comparison against the macro-off build -> identical results.
